// File: rtl/decoder_n_seq.sv
// N-to-2^N one-hot decoder with registered outputs and a built-in
// index sequencer (load / scan up / scan down / hold).
module decoder_n_seq #(
  parameter int   N          = 3,
  parameter int   STRIDE     = 1,
  parameter bit   ACTIVE_LOW = 1'b0,
  localparam int  M          = 2**N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] x,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [M-1:0] y,
  output logic [N-1:0] idx,
  output logic         y_valid,
  output logic         wrap
);

  localparam int CW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STRIDE - 1);
  localparam logic [N-1:0]  IMAX = N'(M - 1);
  localparam logic [M-1:0]  POL  = {M{ACTIVE_LOW}};

  localparam logic [1:0] LOAD    = 2'b00;
  localparam logic [1:0] SCAN_UP = 2'b01;
  localparam logic [1:0] SCAN_DN = 2'b10;
  localparam logic [1:0] HOLD    = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q;
  logic          wrap_d;
  logic [M-1:0]  y_d;
  logic          mode_chg;
  logic          up;

  assign x_ready  = en & (mode == LOAD);
  assign mode_chg = (mode != mode_q);
  assign up       = (mode == SCAN_UP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (mode_chg) cnt_d = '0;
      unique case (mode)
        LOAD: begin
          if (x_valid) begin
            idx_d   = x;
            cnt_d   = '0;
            state_d = ACTIVE;
          end
        end
        SCAN_UP, SCAN_DN: begin
          // entering a scan shows the current idx for a full period
          if (state_q == IDLE || mode_chg) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (cnt_q == CMAX) begin
            cnt_d  = '0;
            idx_d  = up ? idx_q + N'(1) : idx_q - N'(1);
            wrap_d = up ? (idx_q == IMAX) : (idx_q == '0);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HOLD: begin
          state_d = ACTIVE;
        end
        default: ;
      endcase
    end
    if (state_d == ACTIVE) y_d = M'(1) << idx_d;
    else                   y_d = '0;
    y_d = y_d ^ POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= LOAD;
      y       <= POL;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode;
      y       <= y_d;
      y_valid <= (state_d == ACTIVE);
      wrap    <= wrap_d;
    end
  end

  assign idx = idx_q;

endmodule
